// File: rtl/xg_pon_pkg.sv
// XGEM header layout, parsing state encoding and small helpers shared by the
// XG-PON header insert/strip blocks.
package xg_pon_pkg;

  localparam int HDR_WORDS      = 2;
  localparam int PLI_W          = 14;
  localparam int BYTES_PER_BEAT = 4;

  // Word0 fields
  localparam int PLI_MSB  = 31;
  localparam int PLI_LSB  = 18;
  localparam int KEY_MSB  = 17;
  localparam int KEY_LSB  = 16;
  localparam int PORT_MSB = 15;
  localparam int PORT_LSB = 0;

  // Word1 fields
  localparam int OPT_MSB = 31;
  localparam int OPT_LSB = 14;
  localparam int LF_BIT  = 13;
  localparam int HEC_MSB = 12;
  localparam int HEC_LSB = 0;

  typedef enum logic [1:0] {
    HDR0    = 2'd0,
    HDR1    = 2'd1,
    PAYLOAD = 2'd2,
    DISCARD = 2'd3
  } xg_state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Byte-enable mask for the last beat of a payload, given the bytes still owed.
  function automatic logic [3:0] tail_keep(input logic [PLI_W-1:0] rem);
    case (rem)
      PLI_W'(1): return 4'h1;
      PLI_W'(2): return 4'h3;
      PLI_W'(3): return 4'h7;
      default:   return 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/strip_xg_pon_header.sv
// Strips the 2-word XGEM header, trims the payload to PLI bytes and optionally filters on port-ID.
// Payload beats appear 1 cycle after acceptance through one registered stage; stalls on TREADY_in.
module strip_xg_pon_header
  import xg_pon_pkg::*;
#(
  parameter logic [15:0] PORT_ID   = 16'h0001,
  parameter logic        FILTER_EN = 1'b0
) (
  input  logic        axis_clk,
  input  logic        axis_reset,

  input  logic [31:0] axis_TDATA_in,
  input  logic        axis_TVALID_in,
  input  logic [3:0]  axis_TKEEP_in,
  input  logic        axis_TLAST_in,
  input  logic        axis_TUSER_in,
  output logic        axis_TREADY_out,

  output logic [31:0] axis_TDATA_out,
  output logic        axis_TVALID_out,
  output logic [3:0]  axis_TKEEP_out,
  output logic        axis_TLAST_out,
  output logic        axis_TUSER_out,
  input  logic        axis_TREADY_in,

  output logic [15:0] frames_ok_cnt,
  output logic [15:0] frames_drop_cnt,
  output logic [15:0] frames_err_cnt
);

  localparam logic [PLI_W-1:0] BEAT_BYTES = PLI_W'(BYTES_PER_BEAT);

  xg_state_e         state_q, state_d;
  logic [PLI_W-1:0]  pli_q, pli_d;
  logic [PLI_W-1:0]  rem_q, rem_d;
  logic [15:0]       port_q, port_d;
  logic              err_seen_q, err_seen_d;

  logic [31:0]       tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic [3:0]        tkeep_q, tkeep_d;
  logic              tlast_q, tlast_d;
  logic              tuser_q, tuser_d;

  logic [15:0]       ok_q, ok_d;
  logic [15:0]       drop_q, drop_d;
  logic [15:0]       err_q, err_d;

  logic              in_rdy;
  logic              in_beat;
  logic              frame_err;

  // Only the payload state can be stalled by the output register.
  assign in_rdy          = (state_q == PAYLOAD) ? (~tvalid_q | axis_TREADY_in) : 1'b1;
  assign axis_TREADY_out = in_rdy & ~axis_reset;
  assign in_beat         = axis_TVALID_in & axis_TREADY_out;
  assign frame_err       = err_seen_q | axis_TUSER_in;

  always_comb begin
    state_d    = state_q;
    pli_d      = pli_q;
    rem_d      = rem_q;
    port_d     = port_q;
    err_seen_d = err_seen_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tkeep_d    = tkeep_q;
    tlast_d    = tlast_q;
    tuser_d    = tuser_q;
    ok_d       = ok_q;
    drop_d     = drop_q;
    err_d      = err_q;

    if (tvalid_q && axis_TREADY_in) begin
      tvalid_d = 1'b0;
    end

    case (state_q)
      HDR0: begin
        if (in_beat) begin
          pli_d  = axis_TDATA_in[PLI_MSB:PLI_LSB];
          port_d = axis_TDATA_in[PORT_MSB:PORT_LSB];
          if (axis_TLAST_in) begin
            drop_d = sat_inc(drop_q);
          end else begin
            state_d = HDR1;
          end
        end
      end

      HDR1: begin
        if (in_beat) begin
          if (axis_TLAST_in) begin
            drop_d  = sat_inc(drop_q);
            state_d = HDR0;
          end else if ((pli_q == '0) || (FILTER_EN && (port_q != PORT_ID))) begin
            drop_d  = sat_inc(drop_q);
            state_d = DISCARD;
          end else begin
            rem_d      = pli_q;
            err_seen_d = 1'b0;
            state_d    = PAYLOAD;
          end
        end
      end

      PAYLOAD: begin
        if (in_beat) begin
          tvalid_d = 1'b1;
          tdata_d  = axis_TDATA_in;
          if (rem_q <= BEAT_BYTES) begin
            tlast_d = 1'b1;
            tkeep_d = tail_keep(rem_q);
            tuser_d = frame_err;
            if (frame_err) err_d = sat_inc(err_q);
            else           ok_d  = sat_inc(ok_q);
            rem_d   = '0;
            // Anything after the last counted byte is padding to be swallowed.
            state_d = axis_TLAST_in ? HDR0 : DISCARD;
          end else if (axis_TLAST_in) begin
            tlast_d = 1'b1;
            tkeep_d = axis_TKEEP_in;
            tuser_d = 1'b1;
            err_d   = sat_inc(err_q);
            rem_d   = '0;
            state_d = HDR0;
          end else begin
            tlast_d    = 1'b0;
            tkeep_d    = 4'hF;
            tuser_d    = 1'b0;
            rem_d      = rem_q - BEAT_BYTES;
            err_seen_d = frame_err;
          end
        end
      end

      DISCARD: begin
        if (in_beat && axis_TLAST_in) begin
          state_d = HDR0;
        end
      end

      default: state_d = HDR0;
    endcase
  end

  always_ff @(posedge axis_clk or posedge axis_reset) begin
    if (axis_reset) begin
      state_q    <= HDR0;
      pli_q      <= '0;
      rem_q      <= '0;
      port_q     <= '0;
      err_seen_q <= 1'b0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tkeep_q    <= 4'h0;
      tlast_q    <= 1'b0;
      tuser_q    <= 1'b0;
      ok_q       <= '0;
      drop_q     <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      pli_q      <= pli_d;
      rem_q      <= rem_d;
      port_q     <= port_d;
      err_seen_q <= err_seen_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tkeep_q    <= tkeep_d;
      tlast_q    <= tlast_d;
      tuser_q    <= tuser_d;
      ok_q       <= ok_d;
      drop_q     <= drop_d;
      err_q      <= err_d;
    end
  end

  assign axis_TDATA_out  = tdata_q;
  assign axis_TVALID_out = tvalid_q;
  assign axis_TKEEP_out  = tkeep_q;
  assign axis_TLAST_out  = tlast_q;
  assign axis_TUSER_out  = tuser_q;
  assign frames_ok_cnt   = ok_q;
  assign frames_drop_cnt = drop_q;
  assign frames_err_cnt  = err_q;

endmodule

// File: tb/tb_strip_xg_pon_header.sv
// Bench for strip_xg_pon_header: frame-level reference model, directed frames, then randomized traffic.
module tb_strip_xg_pon_header;

  localparam logic [15:0] PID = 16'h0001;

  logic        axis_clk = 1'b0;
  logic        axis_reset;
  logic [31:0] axis_TDATA_in;
  logic        axis_TVALID_in;
  logic [3:0]  axis_TKEEP_in;
  logic        axis_TLAST_in;
  logic        axis_TUSER_in;
  logic        axis_TREADY_out;
  logic [31:0] axis_TDATA_out;
  logic        axis_TVALID_out;
  logic [3:0]  axis_TKEEP_out;
  logic        axis_TLAST_out;
  logic        axis_TUSER_out;
  logic        axis_TREADY_in;
  logic [15:0] frames_ok_cnt;
  logic [15:0] frames_drop_cnt;
  logic [15:0] frames_err_cnt;

  always #5 axis_clk = ~axis_clk;

  strip_xg_pon_header #(.PORT_ID(PID), .FILTER_EN(1'b1)) dut (
    .axis_clk        (axis_clk),
    .axis_reset      (axis_reset),
    .axis_TDATA_in   (axis_TDATA_in),
    .axis_TVALID_in  (axis_TVALID_in),
    .axis_TKEEP_in   (axis_TKEEP_in),
    .axis_TLAST_in   (axis_TLAST_in),
    .axis_TUSER_in   (axis_TUSER_in),
    .axis_TREADY_out (axis_TREADY_out),
    .axis_TDATA_out  (axis_TDATA_out),
    .axis_TVALID_out (axis_TVALID_out),
    .axis_TKEEP_out  (axis_TKEEP_out),
    .axis_TLAST_out  (axis_TLAST_out),
    .axis_TUSER_out  (axis_TUSER_out),
    .axis_TREADY_in  (axis_TREADY_in),
    .frames_ok_cnt   (frames_ok_cnt),
    .frames_drop_cnt (frames_drop_cnt),
    .frames_err_cnt  (frames_err_cnt)
  );

  typedef struct packed {
    logic        user;
    logic        last;
    logic [3:0]  keep;
    logic [31:0] data;
  } beat_t;

  beat_t frame_q[$];
  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    exp_ok = 0, exp_drop = 0, exp_err = 0;
  int    beats_seen = 0;
  beat_t last_seen;
  int    rdy_mode = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  function automatic int sat16(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic chk_cnt(input string nm);
    chk({nm, "_ok"},   64'(frames_ok_cnt),   64'(exp_ok));
    chk({nm, "_drop"}, 64'(frames_drop_cnt), 64'(exp_drop));
    chk({nm, "_err"},  64'(frames_err_cnt),  64'(exp_err));
  endtask

  // npay < 0: single-word frame; npay == 0: header only; user_idx < 0: no TUSER.
  task automatic build_frame(input int pli, input int port, input int npay, input int user_idx);
    beat_t b;
    frame_q.delete();
    b.data = {pli[13:0], 2'b00, port[15:0]};
    b.keep = 4'hF;
    b.user = 1'b0;
    b.last = (npay < 0);
    frame_q.push_back(b);
    if (npay >= 0) begin
      b.data = $urandom;
      b.last = (npay == 0);
      frame_q.push_back(b);
      for (int i = 0; i < npay; i++) begin
        b.data = $urandom;
        b.user = (i == user_idx);
        b.last = (i == npay - 1);
        b.keep = b.last ? 4'($urandom % 16) : 4'hF;
        frame_q.push_back(b);
      end
    end
  endtask

  // Expected output of one TLAST-delimited frame, worked out from byte counts.
  task automatic model_frame();
    int    n, pli, port, p, k, nout;
    logic  anyu;
    beat_t b, e;
    n = frame_q.size();
    if (n <= 2) begin
      exp_drop = sat16(exp_drop);
      return;
    end
    pli  = int'(frame_q[0].data[31:18]);
    port = int'(frame_q[0].data[15:0]);
    if (pli == 0 || port != int'(PID)) begin
      exp_drop = sat16(exp_drop);
      return;
    end
    p    = n - 2;
    k    = (pli + 3) / 4;
    nout = (p >= k) ? k : p;
    anyu = 1'b0;
    for (int i = 0; i < nout; i++) begin
      b    = frame_q[2 + i];
      anyu = anyu | b.user;
      e.data = b.data;
      e.last = 1'b0;
      e.keep = 4'hF;
      e.user = 1'b0;
      if (p >= k && i == k - 1) begin
        e.last = 1'b1;
        e.user = anyu;
        case (pli % 4)
          1:       e.keep = 4'h1;
          2:       e.keep = 4'h3;
          3:       e.keep = 4'h7;
          default: e.keep = 4'hF;
        endcase
      end else if (p < k && i == p - 1) begin
        e.last = 1'b1;
        e.user = 1'b1;
        e.keep = b.keep;
      end
      exp_q.push_back(e);
    end
    if (p >= k && !anyu) exp_ok = sat16(exp_ok);
    else                 exp_err = sat16(exp_err);
  endtask

  task automatic send_beat(input beat_t b);
    int   guard;
    logic done;
    axis_TDATA_in  = b.data;
    axis_TKEEP_in  = b.keep;
    axis_TLAST_in  = b.last;
    axis_TUSER_in  = b.user;
    axis_TVALID_in = 1'b1;
    guard = 0;
    done  = 1'b0;
    while (!done) begin
      @(negedge axis_clk);
      if (axis_TREADY_out) begin
        @(posedge axis_clk);
        #1;
        done = 1'b1;
      end else begin
        guard++;
        if (guard > 2000) begin
          checks++;
          errors++;
          $display("FAIL input_handshake: TREADY_out stuck at %0b, expected 1", axis_TREADY_out);
          done = 1'b1;
        end
      end
    end
    axis_TVALID_in = 1'b0;
  endtask

  task automatic send_frame(input logic gaps);
    for (int i = 0; i < frame_q.size(); i++) begin
      if (gaps && ($urandom % 3 == 0)) begin
        @(posedge axis_clk);
        #1;
      end
      send_beat(frame_q[i]);
    end
  endtask

  task automatic run_frame(input int pli, input int port, input int npay, input int user_idx, input logic gaps);
    build_frame(pli, port, npay, user_idx);
    model_frame();
    send_frame(gaps);
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 5000) begin
      @(posedge axis_clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d beats still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge axis_clk);
    #1;
  endtask

  initial begin
    axis_TREADY_in = 1'b1;
    forever begin
      @(posedge axis_clk);
      #1;
      case (rdy_mode)
        0:       axis_TREADY_in = 1'b1;
        1:       axis_TREADY_in = ~axis_TREADY_in;
        2:       axis_TREADY_in = ($urandom % 4 != 0);
        default: axis_TREADY_in = 1'b0;
      endcase
    end
  end

  // Output checker: every handshake against the model queue, every stall for stability.
  initial begin
    beat_t cur, snap, e;
    logic  stall_prev;
    stall_prev = 1'b0;
    snap = '0;
    forever begin
      @(negedge axis_clk);
      if (axis_reset) begin
        stall_prev = 1'b0;
      end else begin
        cur = {axis_TUSER_out, axis_TLAST_out, axis_TKEEP_out, axis_TDATA_out};
        if (stall_prev) begin
          chk("hold_valid", 64'(axis_TVALID_out), 64'd1);
          chk("hold_fields", 64'(cur), 64'(snap));
        end
        if (axis_TVALID_out && axis_TREADY_in) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %0h, expected no beat", cur);
          end else begin
            e = exp_q.pop_front();
            chk("out_beat", 64'(cur), 64'(e));
            beats_seen++;
            last_seen = cur;
          end
        end
        stall_prev = axis_TVALID_out && !axis_TREADY_in;
        snap = cur;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pli, port, k, npay, uidx, sel;
    axis_reset     = 1'b0;
    axis_TDATA_in  = '0;
    axis_TVALID_in = 1'b0;
    axis_TKEEP_in  = '0;
    axis_TLAST_in  = 1'b0;
    axis_TUSER_in  = 1'b0;
    last_seen      = '0;
    #2 axis_reset = 1'b1;
    #20;
    chk("rst_tvalid", 64'(axis_TVALID_out), 64'd0);
    chk("rst_tready", 64'(axis_TREADY_out), 64'd0);
    chk("rst_fields", 64'({axis_TUSER_out, axis_TLAST_out, axis_TKEEP_out, axis_TDATA_out}), 64'd0);
    chk_cnt("rst");
    @(posedge axis_clk);
    #1 axis_reset = 1'b0;
    #1 chk("idle_tready", 64'(axis_TREADY_out), 64'd1);

    // Full 64-byte frame
    beats_seen = 0;
    run_frame(64, 1, 16, -1, 1'b0);
    wait_drain();
    chk("t_full_beats", 64'(beats_seen), 64'd16);
    chk("t_full_tail", 64'({last_seen.last, last_seen.user, last_seen.keep}), 64'h2F);
    chk("t_full_ok", 64'(frames_ok_cnt), 64'd1);
    chk_cnt("t_full");

    // 61 bytes: one byte valid on the last beat
    beats_seen = 0;
    run_frame(61, 1, 16, -1, 1'b0);
    wait_drain();
    chk("t_61_beats", 64'(beats_seen), 64'd16);
    chk("t_61_tail", 64'({last_seen.last, last_seen.user, last_seen.keep}), 64'h21);

    // 62 and 63 bytes
    run_frame(62, 1, 16, -1, 1'b0);
    wait_drain();
    chk("t_62_keep", 64'(last_seen.keep), 64'h3);
    run_frame(63, 1, 16, -1, 1'b0);
    wait_drain();
    chk("t_63_keep", 64'(last_seen.keep), 64'h7);

    // Two padding words after the payload
    beats_seen = 0;
    run_frame(64, 1, 18, -1, 1'b0);
    wait_drain();
    chk("t_pad_beats", 64'(beats_seen), 64'd16);
    chk("t_pad_ok", 64'(frames_ok_cnt), 64'd5);
    chk_cnt("t_pad");

    // Filtered port, then idle frame
    beats_seen = 0;
    run_frame(32, 2, 8, -1, 1'b0);
    wait_drain();
    chk("t_filt_beats", 64'(beats_seen), 64'd0);
    chk("t_filt_drop", 64'(frames_drop_cnt), 64'd1);
    run_frame(0, 1, 3, -1, 1'b0);
    wait_drain();
    chk("t_idle_drop", 64'(frames_drop_cnt), 64'd2);

    // Truncated at payload word 8
    beats_seen = 0;
    run_frame(64, 1, 8, -1, 1'b0);
    wait_drain();
    chk("t_trunc_beats", 64'(beats_seen), 64'd8);
    chk("t_trunc_tail", 64'({last_seen.last, last_seen.user}), 64'h3);
    chk("t_trunc_err", 64'(frames_err_cnt), 64'd1);

    // Errored payload beat mid-frame
    run_frame(16, 1, 4, 1, 1'b0);
    wait_drain();
    chk("t_user_tail", 64'({last_seen.last, last_seen.user}), 64'h3);
    chk("t_user_err", 64'(frames_err_cnt), 64'd2);
    chk_cnt("t_user");

    // Alternating TREADY_in
    rdy_mode   = 1;
    beats_seen = 0;
    run_frame(40, 1, 10, -1, 1'b0);
    wait_drain();
    chk("t_toggle_beats", 64'(beats_seen), 64'd10);
    chk_cnt("t_toggle");

    // Reset while an output beat is stalled on payload word 5
    rdy_mode = 0;
    build_frame(64, 1, 16, -1);
    for (int i = 2; i < 5; i++) exp_q.push_back('{user: 1'b0, last: 1'b0, keep: 4'hF, data: frame_q[i].data});
    for (int i = 0; i < 5; i++) send_beat(frame_q[i]);
    wait_drain();
    rdy_mode = 3;
    repeat (2) @(posedge axis_clk);
    #2;
    send_beat(frame_q[5]);
    repeat (2) @(posedge axis_clk);
    #1;
    chk("t_rst_pending", 64'(axis_TVALID_out), 64'd1);
    axis_TDATA_in  = frame_q[6].data;
    axis_TKEEP_in  = frame_q[6].keep;
    axis_TLAST_in  = 1'b0;
    axis_TUSER_in  = 1'b0;
    axis_TVALID_in = 1'b1;
    axis_reset     = 1'b1;
    #1;
    chk("t_rst_tvalid", 64'(axis_TVALID_out), 64'd0);
    chk("t_rst_tready", 64'(axis_TREADY_out), 64'd0);
    exp_q.delete();
    exp_ok = 0; exp_drop = 0; exp_err = 0;
    repeat (2) @(posedge axis_clk);
    #1;
    axis_TVALID_in = 1'b0;
    axis_reset     = 1'b0;
    rdy_mode       = 0;
    chk_cnt("t_rst_cnt");
    beats_seen = 0;
    run_frame(16, 1, 4, -1, 1'b0);
    wait_drain();
    chk("t_after_rst_beats", 64'(beats_seen), 64'd4);
    chk("t_after_rst_ok", 64'(frames_ok_cnt), 64'd1);

    // Randomized traffic with random backpressure and input gaps
    rdy_mode = 2;
    for (int f = 0; f < 40; f++) begin
      pli  = ($urandom % 10 == 0) ? 0 : int'($urandom_range(1, 80));
      port = ($urandom % 7 == 0) ? 2 : 1;
      k    = (pli + 3) / 4;
      sel  = int'($urandom % 8);
      case (sel)
        0:       npay = -1;
        1:       npay = 0;
        2:       npay = (k > 1) ? int'($urandom_range(1, k - 1)) : k;
        6, 7:    npay = k + int'($urandom_range(1, 3));
        default: npay = k;
      endcase
      uidx = (npay > 0 && ($urandom % 6 == 0)) ? int'($urandom_range(0, npay - 1)) : -1;
      run_frame(pli, port, npay, uidx, 1'b1);
    end
    wait_drain();
    chk_cnt("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/strip_xg_pon_header.md
STRIP_XG_PON_HEADER -- requirements
Module: strip_XG_PON_header

Interface
REQ-001 The block SHALL have parameter PORT_ID, default 16'h0001, the XGEM port-ID accepted when filtering is on.
REQ-002 The block SHALL have parameter FILTER_EN, default 1'b0; 1 drops frames whose port-ID differs from PORT_ID.
REQ-003 The block SHALL have one clock and one reset; reset is asynchronous and active-high: axis_clk  in  1  stream clock; axis_reset  in  1  async active-high reset.
REQ-004 The block SHALL have these input-stream ports: axis_TDATA_in in 32; axis_TVALID_in in 1; axis_TKEEP_in in 4; axis_TLAST_in in 1; axis_TUSER_in in 1 (error flag); axis_TREADY_out out 1.
REQ-005 The block SHALL have these output-stream ports: axis_TDATA_out out 32; axis_TVALID_out out 1; axis_TKEEP_out out 4; axis_TLAST_out out 1; axis_TUSER_out out 1 (error flag); axis_TREADY_in in 1.
REQ-006 The block SHALL have these status ports: frames_ok_cnt out 16; frames_drop_cnt out 16; frames_err_cnt out 16. All three counters saturate at 16'hFFFF.

Function
REQ-007 The input SHALL be XGEM frames as produced by add_XG_PON_header, laid out as follows.
- Word0: PLI = [31:18], key_index = [17:16], port_id = [15:0].
- Word1: options = [31:14], LF = [13], HEC = [12:0].
- Payload follows from word2; byte 0 is on tdata[7:0].
REQ-008 The FSM states SHALL be HDR0, HDR1, PAYLOAD and DISCARD; the reset state is HDR0.
REQ-009 In HDR0, on an input beat, the block SHALL latch PLI and port_id.
- Next state is HDR1.
- If that beat also has TLAST, the block counts a drop and stays in HDR0.
REQ-010 In HDR1, on an input beat, the block SHALL decide the frame's fate.
- PLI==0, or FILTER_EN with port_id!=PORT_ID: go to DISCARD and count a drop.
- Otherwise: load remaining = PLI and go to PAYLOAD.
- If the beat has TLAST: count a drop and go to HDR0.
REQ-011 Header words SHALL never appear on the output. axis_TREADY_out SHALL be 1 in HDR0, HDR1 and DISCARD.
REQ-012 In PAYLOAD, axis_TREADY_out SHALL equal (~axis_TVALID_out | axis_TREADY_in), i.e. a single registered output stage.
REQ-013 In PAYLOAD, each accepted beat SHALL produce one output beat one cycle later, with TDATA unchanged, and SHALL subtract 4 from remaining, saturating at 0.
REQ-014 When remaining<=4 on a PAYLOAD beat, the output beat SHALL carry TLAST=1 and TKEEP set by remaining.
- remaining 4, 3, 2, 1 gives TKEEP 4'hF, 4'h7, 4'h3, 4'h1.
- All other payload beats carry TKEEP=4'hF.
REQ-015 After the REQ-014 beat, the block SHALL go to HDR0 if the input beat had TLAST, otherwise to DISCARD; frames_ok_cnt increments unless the beat is flagged as in REQ-017.
REQ-016 DISCARD SHALL consume input beats (trailing padding, idle and filtered frames) without output until a TLAST beat, then go to HDR0.
REQ-017 Truncation: input TLAST in PAYLOAD with remaining>4 SHALL emit that beat with TLAST=1, TUSER=1 and TKEEP=axis_TKEEP_in, then go to HDR0.
- frames_err_cnt increments; frames_ok_cnt does not.
- Any payload beat with axis_TUSER_in=1 also forces TUSER=1 on the final output beat and counts an error instead of an ok.
REQ-018 Output SHALL hold all fields stable while TVALID=1 and TREADY_in=0; TVALID never drops without a handshake.
REQ-019 Latency SHALL be exactly 1 cycle from input payload handshake to TVALID_out with TREADY_in=1; sustained throughput is 1 beat per cycle.
REQ-020 When a counter increment and saturation coincide, the counter SHALL hold at 16'hFFFF.

Reset
REQ-021 axis_reset=1 SHALL asynchronously force the following values:
- State HDR0, remaining 0.
- axis_TVALID_out 0, axis_TLAST_out 0, axis_TUSER_out 0.
- axis_TKEEP_out 4'h0, axis_TDATA_out 0.
- All counters 0.
REQ-022 Reset asserted mid-frame SHALL abandon the frame with no further output beat. After release, parsing SHALL start at the next input beat as word0.
REQ-023 axis_TREADY_out SHALL be 0 while axis_reset=1.

Structure
REQ-024 A shared package (xg_pon_pkg) SHALL hold the header field bit positions, the header word count (2), the PLI width (14) and the state encoding; add_XG_PON_header SHALL use the same package.
REQ-025 The block SHALL be one module with no sub-modules; the output register stage is inline.

Verification
REQ-026 PLI=64, port 0x0001, 16 payload words + TLAST -> 16 output beats, last TKEEP=F, TLAST on beat 16, frames_ok_cnt=1.
REQ-027 PLI=61, 16 payload words + TLAST -> 16 output beats, last TKEEP=4'h1, TUSER=0.
REQ-028 PLI=64, 18 payload words (2 pad) -> 16 beats out, TLAST on beat 16, the 2 pad words consumed with no output.
REQ-029 FILTER_EN=1, port 0x0002, PLI=32 -> no output beats, frames_drop_cnt=1; a PLI=0 idle frame also gives drop +1.
REQ-030 PLI=64, TLAST on payload word 8 -> 8 beats out, the last with TLAST=1, TUSER=1, and frames_err_cnt=1.
REQ-031 TREADY_in toggling 1010… during a PLI=40 frame -> 10 beats out, data identical and in order; also assert reset at payload word 5 -> TVALID_out=0 immediately and the next frame is parsed correctly.
